// File: rtl/multicycle_alu.sv
// Clocked MIPS ALU: single-cycle ops plus iterative MULTU/DIVU into HI/LO.
// Latency: 1 cycle single-cycle ops, BIT_WIDTH+1 MULTU/DIVU, 2 cycles DIVU by zero.
// Backpressure: busy high during iteration; start is ignored (not queued) while busy or in FIN.
module multicycle_alu #(
   parameter int BIT_WIDTH = 32,
   parameter int BIT_SEL   = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [BIT_SEL:0]     ALUControl,
   input  logic [BIT_WIDTH-1:0] SrcA,
   input  logic [BIT_WIDTH-1:0] SrcB,
   output logic [BIT_WIDTH-1:0] ALUResult,
   output logic                 Zero,
   output logic [BIT_WIDTH-1:0] Hi,
   output logic [BIT_WIDTH-1:0] Lo,
   output logic                 busy,
   output logic                 done,
   output logic                 div_by_zero
);

   localparam int SW = $clog2(BIT_WIDTH);
   localparam int CW = SW + 1;
   localparam int HW = BIT_WIDTH / 2;
   localparam int OW = BIT_SEL + 2;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [BIT_WIDTH-1:0] acc;      // partial product (upper half) or remainder
   logic [BIT_WIDTH-1:0] q;        // multiplier or quotient; holds dividend for divide-by-zero
   logic [BIT_WIDTH-1:0] opb;      // multiplicand or divisor
   logic                 div_mode;
   logic                 dz;

   logic [OW-1:0]        op_ext;
   logic [3:0]           op_lo;
   logic                 op_undef;
   logic [BIT_WIDTH-1:0] sc_res;
   logic                 sc_zero;
   logic                 sc_keep;
   logic                 is_mul;
   logic                 is_div;

   logic [BIT_WIDTH:0]   mul_sum;
   logic [BIT_WIDTH:0]   div_shift;
   logic [BIT_WIDTH:0]   div_diff;
   logic                 div_ge;
   logic [BIT_WIDTH-1:0] nxt_acc;
   logic [BIT_WIDTH-1:0] nxt_q;

   // Decode the operation and compute the single-cycle result and compare flag.
   always_comb begin
      op_ext   = OW'(ALUControl);
      op_lo    = op_ext[3:0];
      op_undef = (op_ext > OW'(15));
      sc_res   = '0;
      sc_zero  = 1'b0;
      sc_keep  = 1'b0;
      if (!op_undef) begin
         case (op_lo)
            4'd0:  sc_res = SrcA + SrcB;
            4'd1:  sc_res = SrcA & SrcB;
            4'd2:  sc_res = ~(SrcA | SrcB);
            4'd3:  sc_res = SrcA | SrcB;
            4'd4:  sc_res = {{(BIT_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            4'd5:  sc_res = SrcB << SrcA[SW-1:0];
            4'd6:  sc_res = SrcB >> SrcA[SW-1:0];
            4'd7:  sc_res = SrcA - SrcB;
            4'd10: begin sc_keep = 1'b1; sc_zero = (SrcA == SrcB); end
            4'd11: begin sc_keep = 1'b1; sc_zero = (SrcA != SrcB); end
            4'd12: sc_res = SrcB;
            4'd13: sc_res = SrcA;
            4'd14: sc_res = {SrcB[HW-1:0], {HW{1'b0}}};
            4'd15: sc_res = {{(BIT_WIDTH-1){1'b0}}, (SrcA < SrcB)};
            default: sc_res = '0;
         endcase
      end
   end

   assign is_mul = !op_undef && (op_lo == 4'd9);
   assign is_div = !op_undef && (op_lo == 4'd8);

   // One iteration step: shift-add for multiply, restoring subtract for divide.
   always_comb begin
      mul_sum   = {1'b0, acc} + ({(BIT_WIDTH+1){q[0]}} & {1'b0, opb});
      div_shift = {acc, q[BIT_WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opb});
      div_diff  = div_shift - {1'b0, opb};
      if (div_mode) begin
         nxt_acc = div_ge ? div_diff[BIT_WIDTH-1:0] : div_shift[BIT_WIDTH-1:0];
         nxt_q   = {q[BIT_WIDTH-2:0], div_ge};
      end else begin
         nxt_acc = mul_sum[BIT_WIDTH:1];
         nxt_q   = {mul_sum[0], q[BIT_WIDTH-1:1]};
      end
   end

   // Control FSM with registered outputs; done and div_by_zero are single-cycle pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         q           <= '0;
         opb         <= '0;
         div_mode    <= 1'b0;
         dz          <= 1'b0;
         ALUResult   <= '0;
         Zero        <= 1'b0;
         Hi          <= '0;
         Lo          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (is_mul || is_div) begin
                     opb      <= SrcB;
                     q        <= SrcA;
                     acc      <= '0;
                     div_mode <= is_div;
                     dz       <= is_div && (SrcB == '0);
                     // Divide by zero skips iteration: one RUN cycle, then FIN.
                     cnt      <= (is_div && (SrcB == '0)) ? CW'(1) : CW'(BIT_WIDTH);
                     busy     <= 1'b1;
                     state    <= RUN;
                  end else begin
                     if (!sc_keep) ALUResult <= sc_res;
                     Zero <= sc_zero;
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               acc <= nxt_acc;
               q   <= nxt_q;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  Zero  <= 1'b0;
                  if (dz) begin
                     Hi          <= q;
                     Lo          <= '1;
                     ALUResult   <= '1;
                     div_by_zero <= 1'b1;
                  end else begin
                     Hi        <= nxt_acc;
                     Lo        <= nxt_q;
                     ALUResult <= nxt_q;
                  end
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu with a queue scoreboard of expected results.
// Latency: expected latency and busy-cycle count are checked per operation.
// Backpressure: exercises a start issued while busy, which must be dropped.
module tb_multicycle_alu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  ALUControl = '0;
   logic [31:0] SrcA = '0;
   logic [31:0] SrcB = '0;
   logic [31:0] ALUResult;
   logic        Zero;
   logic [31:0] Hi;
   logic [31:0] Lo;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        zero;
      logic        dz;
      int          lat;
      int          bcyc;
   } exp_t;

   exp_t sb[$];

   // Model state for values that persist across operations.
   logic [31:0] m_res = '0;
   logic [31:0] m_hi  = '0;
   logic [31:0] m_lo  = '0;

   multicycle_alu #(.BIT_WIDTH(32), .BIT_SEL(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ALUControl(ALUControl),
      .SrcA(SrcA), .SrcB(SrcB), .ALUResult(ALUResult), .Zero(Zero),
      .Hi(Hi), .Lo(Lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [63:0] p;
      logic [4:0]  sh;
      sh = a[4:0];
      e.zero = 1'b0;
      e.dz   = 1'b0;
      e.lat  = 1;
      e.bcyc = 0;
      case (op)
         4'd0:  m_res = a + b;
         4'd1:  m_res = a & b;
         4'd2:  m_res = ~(a | b);
         4'd3:  m_res = a | b;
         4'd4:  m_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd15: m_res = (a < b) ? 32'd1 : 32'd0;
         4'd5:  m_res = b << sh;
         4'd6:  m_res = b >> sh;
         4'd7:  m_res = a - b;
         4'd10: e.zero = (a == b);
         4'd11: e.zero = (a != b);
         4'd12: m_res = b;
         4'd13: m_res = a;
         4'd14: m_res = {b[15:0], 16'h0000};
         4'd9: begin
            p = {32'd0, a} * {32'd0, b};
            m_hi = p[63:32]; m_lo = p[31:0]; m_res = m_lo;
            e.lat = 33; e.bcyc = 32;
         end
         default: begin
            if (b == 32'd0) begin
               m_hi = a; m_lo = 32'hFFFF_FFFF; e.dz = 1'b1;
               e.lat = 2; e.bcyc = 1;
            end else begin
               m_hi = a % b; m_lo = a / b;
               e.lat = 33; e.bcyc = 32;
            end
            m_res = m_lo;
         end
      endcase
      e.res = m_res;
      e.hi  = m_hi;
      e.lo  = m_lo;
      sb.push_back(e);
   endtask

   // Issue one op; optionally inject an add start at cycle inject_at (must be ignored).
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at);
      exp_t e;
      int cycles;
      int busyc;
      push_exp(op, a, b);
      @(negedge clk);
      start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
      @(negedge clk);
      start = 1'b0;
      cycles = 1;
      busyc  = 0;
      while (!done && cycles < 100) begin
         if (busy) busyc++;
         if (cycles == inject_at) begin
            start = 1'b1; ALUControl = 4'd0; SrcA = 32'd1; SrcB = 32'd2;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
      e = sb.pop_front();
      check("done_seen", {63'd0, done}, 64'd1);
      check("latency", 64'(cycles), 64'(e.lat));
      check("busy_cycles", 64'(busyc), 64'(e.bcyc));
      check("busy_at_done", {63'd0, busy}, 64'd0);
      check("alu_result", {32'd0, ALUResult}, {32'd0, e.res});
      check("zero", {63'd0, Zero}, {63'd0, e.zero});
      check("hi", {32'd0, Hi}, {32'd0, e.hi});
      check("lo", {32'd0, Lo}, {32'd0, e.lo});
      check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
      @(negedge clk);
      check("done_single_pulse", {63'd0, done}, 64'd0);
      check("dz_single_pulse", {63'd0, div_by_zero}, 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_result"}, {32'd0, ALUResult}, 64'd0);
      check({tag, "_zero"}, {63'd0, Zero}, 64'd0);
      check({tag, "_hi"}, {32'd0, Hi}, 64'd0);
      check({tag, "_lo"}, {32'd0, Lo}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_done"}, {63'd0, done}, 64'd0);
      check({tag, "_dz"}, {63'd0, div_by_zero}, 64'd0);
   endtask

   initial begin
      int dones;
      logic [31:0] ra;
      logic [31:0] rb;

      #1 rst_n = 1'b0;
      #2 check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(4'd0,  32'd5,          32'hFFFF_FFFF, 0);
      run_op(4'd14, 32'd0,          32'h0000_1234, 0);
      run_op(4'd2,  32'd0,          32'd0,         0);
      run_op(4'd4,  32'hFFFF_FFFF,  32'd1,         0);
      run_op(4'd15, 32'hFFFF_FFFF,  32'd1,         0);
      run_op(4'd5,  32'd4,          32'd3,         0);
      run_op(4'd6,  32'd36,         32'h8000_0000, 0);
      run_op(4'd7,  32'd3,          32'd5,         0);
      run_op(4'd1,  32'hF0F0_1234,  32'h0FF0_FF00, 0);
      run_op(4'd3,  32'hF000_0000,  32'h0000_000F, 0);
      run_op(4'd13, 32'hCAFE_BABE,  32'd1,         0);
      run_op(4'd12, 32'hCAFE_BABE,  32'h1357_9BDF, 0);
      run_op(4'd9,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
      run_op(4'd8,  32'd100,        32'd7,         0);
      run_op(4'd8,  32'd9,          32'd0,         0);
      run_op(4'd9,  32'd7,          32'd6,         5);
      run_op(4'd10, 32'd1,          32'd1,         0);
      run_op(4'd8,  32'hFFFF_FFFF,  32'd1,         0);
      run_op(4'd8,  32'd3,          32'hFFFF_FFFF, 0);

      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_op((i % 2 == 0) ? 4'd9 : 4'd8, ra, rb, 0);
      end

      // Reset in the middle of a MULTU: everything clears at once, no done follows.
      @(negedge clk);
      start = 1'b1; ALUControl = 4'd9; SrcA = 32'd123; SrcB = 32'd456;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("busy_before_reset", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1 check_all_zero("mid_run_reset");
      m_res = '0; m_hi = '0; m_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("no_done_after_abort", 64'(dones), 64'd0);

      run_op(4'd11, 32'd3, 32'd3, 0);
      run_op(4'd10, 32'd3, 32'd3, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
